// File: rtl/count_sched_ctrl_if.sv
// Bundle between the scheduler and its two requesters plus the shared counter.
// The slave side is the scheduler itself.
interface count_sched_ctrl_if #(
   parameter int CNT_W = 4
);
   logic             req0;
   logic             req1;
   logic [CNT_W-1:0] len0;
   logic [CNT_W-1:0] len1;
   logic             ack0;
   logic             ack1;
   logic             done0;
   logic             done1;
   logic             busy;
   logic             owner;
   logic             fault;
   logic             cnt_rst;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_data;
   logic [CNT_W-1:0] cnt_q;

   modport master (
      output req0, req1, len0, len1, cnt_q,
      input  ack0, ack1, done0, done1, busy, owner, fault,
      input  cnt_rst, cnt_load, cnt_data
   );

   modport slave (
      input  req0, req1, len0, len1, cnt_q,
      output ack0, ack1, done0, done1, busy, owner, fault,
      output cnt_rst, cnt_load, cnt_data
   );
endinterface

// File: rtl/count_sched_ctrl.sv
// Round-robin scheduler sharing one external loadable up-counter
// between two requesters, with a RUN-state watchdog.
module count_sched_ctrl #(
   parameter int CNT_W = 4,
   parameter int WDOG  = 17
) (
   input logic               clk,
   input logic               reset,
   count_sched_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] TERM = '1;
   localparam int WD_W = $clog2(WDOG + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic             grant, gsel;
   logic             term, wd_exp;
   logic [WD_W-1:0]  wd, wd_nx;
   logic             ack0, ack1, done0, done1;
   logic             ack0_nx, ack1_nx, done0_nx, done1_nx;
   logic             busy, owner, fault, cnt_rst, cnt_load;
   logic             busy_nx, owner_nx, fault_nx, load_nx;
   logic [CNT_W-1:0] cnt_data, data_nx;

   assign term   = (bus.cnt_q == TERM);
   assign wd_exp = (wd == WD_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         wd       <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         busy     <= 1'b0;
         owner    <= 1'b1;
         fault    <= 1'b0;
         cnt_rst  <= 1'b1;
         cnt_load <= 1'b0;
         cnt_data <= '0;
      end else begin
         state    <= state_nx;
         wd       <= wd_nx;
         ack0     <= ack0_nx;
         ack1     <= ack1_nx;
         done0    <= done0_nx;
         done1    <= done1_nx;
         busy     <= busy_nx;
         owner    <= owner_nx;
         fault    <= fault_nx;
         cnt_rst  <= 1'b0;
         cnt_load <= load_nx;
         cnt_data <= data_nx;
      end
   end

   // With both requesting, the one that did not go last wins
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      gsel     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant    = 1'b1;
               gsel     = (bus.req0 && bus.req1) ? ~owner : bus.req1;
               state_nx = LOAD;
            end
         end
         LOAD: state_nx = RUN;
         RUN: begin
            if (term)
               state_nx = DONE;
            else if (wd_exp)
               state_nx = IDLE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ack0_nx  = 1'b0;
      ack1_nx  = 1'b0;
      done0_nx = 1'b0;
      done1_nx = 1'b0;
      load_nx  = 1'b0;
      busy_nx  = busy;
      owner_nx = owner;
      fault_nx = fault;
      data_nx  = cnt_data;
      wd_nx    = wd;
      unique case (state)
         IDLE: begin
            if (grant) begin
               ack0_nx  = ~gsel;
               ack1_nx  = gsel;
               owner_nx = gsel;
               load_nx  = 1'b1;
               data_nx  = gsel ? ~bus.len1 : ~bus.len0;
               busy_nx  = 1'b1;
            end
         end
         LOAD: wd_nx = '0;
         RUN: begin
            if (term) begin
               done0_nx = ~owner;
               done1_nx = owner;
            end else if (wd_exp) begin
               fault_nx = 1'b1;
               busy_nx  = 1'b0;
            end else begin
               wd_nx = wd + 1'b1;
            end
         end
         DONE: busy_nx = 1'b0;
         default: busy_nx = 1'b0;
      endcase
   end

   assign bus.ack0     = ack0;
   assign bus.ack1     = ack1;
   assign bus.done0    = done0;
   assign bus.done1    = done1;
   assign bus.busy     = busy;
   assign bus.owner    = owner;
   assign bus.fault    = fault;
   assign bus.cnt_rst  = cnt_rst;
   assign bus.cnt_load = cnt_load;
   assign bus.cnt_data = cnt_data;
endmodule

// File: tb/tb_count_sched_ctrl.sv
// Directed bench for count_sched_ctrl with a behavioural counter
// that can be made to stall at q=4.
module tb_count_sched_ctrl;
   logic clk;
   logic reset;
   logic stall;
   int   nvec;
   int   nerr;

   count_sched_ctrl_if #(.CNT_W(4)) bus ();

   count_sched_ctrl #(
      .CNT_W(4),
      .WDOG (17)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.cnt_rst)
         bus.cnt_q <= 4'd0;
      else if (bus.cnt_load)
         bus.cnt_q <= bus.cnt_data;
      else if (!(stall && bus.cnt_q == 4'd4))
         bus.cnt_q <= bus.cnt_q + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grant(input string tag, input bit who,
                        input logic [3:0] l);
      logic [3:0] d;
      d = ~l;
      tick();
      chk({tag, "_ack"}, who ? bus.ack1 : bus.ack0, 1);
      chk({tag, "_nack"}, who ? bus.ack0 : bus.ack1, 0);
      chk({tag, "_own"}, bus.owner, who);
      chk({tag, "_ld"}, bus.cnt_load, 1);
      chk({tag, "_data"}, bus.cnt_data, d);
      chk({tag, "_busy"}, bus.busy, 1);
   endtask

   task automatic wait_done(input string tag, input bit who,
                            input logic [3:0] q0, input int lat);
      int         n;
      bit         seen;
      bit         wrong;
      logic [3:0] qf;
      n     = 0;
      seen  = 0;
      wrong = 0;
      qf    = 4'd0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (n == 1)
            qf = bus.cnt_q;
         if (who ? bus.done1 : bus.done0)
            seen = 1;
         if (who ? bus.done0 : bus.done1)
            wrong = 1;
      end
      chk({tag, "_q0"}, qf, q0);
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_xdone"}, wrong, 0);
      chk({tag, "_bsy1"}, bus.busy, 1);
      tick();
      chk({tag, "_dn0"}, who ? bus.done1 : bus.done0, 0);
      chk({tag, "_bsy0"}, bus.busy, 0);
   endtask

   initial begin
      int n;
      bit seen;
      nvec     = 0;
      nerr     = 0;
      stall    = 1'b0;
      reset    = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.len0 = 4'd0;
      bus.len1 = 4'd0;

      tick();
      tick();
      chk("rst_ack0", bus.ack0, 0);
      chk("rst_ack1", bus.ack1, 0);
      chk("rst_done", {bus.done1, bus.done0}, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_owner", bus.owner, 1);
      chk("rst_fault", bus.fault, 0);
      chk("rst_load", bus.cnt_load, 0);
      chk("rst_data", bus.cnt_data, 0);
      chk("rst_crst", bus.cnt_rst, 1);
      reset = 1'b1;
      tick();
      chk("rel_crst", bus.cnt_rst, 0);
      chk("rel_busy", bus.busy, 0);

      bus.req0 = 1'b1;
      bus.len0 = 4'd5;
      grant("l5", 0, 4'd5);
      bus.req0 = 1'b0;
      bus.len0 = 4'd9;
      wait_done("l5", 0, 4'd10, 7);

      bus.req0 = 1'b1;
      bus.len0 = 4'd15;
      grant("l15", 0, 4'd15);
      bus.req0 = 1'b0;
      wait_done("l15", 0, 4'd0, 17);

      bus.req1 = 1'b1;
      bus.len1 = 4'd0;
      grant("l0", 1, 4'd0);
      bus.req1 = 1'b0;
      wait_done("l0", 1, 4'd15, 2);

      bus.len0 = 4'd3;
      bus.len1 = 4'd3;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         grant($sformatf("rr%0d", i), i[0], 4'd3);
         wait_done($sformatf("rr%0d", i), i[0], 4'd12, 5);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();

      stall    = 1'b1;
      bus.req0 = 1'b1;
      bus.len0 = 4'd13;
      grant("wd", 0, 4'd13);
      bus.req0 = 1'b0;
      n    = 0;
      seen = 0;
      while (!bus.fault && n < 40) begin
         tick();
         n++;
         if (bus.done0 || bus.done1)
            seen = 1;
      end
      chk("wd_lat", n, 18);
      chk("wd_nodone", seen, 0);
      chk("wd_busy", bus.busy, 0);
      stall = 1'b0;
      tick();
      tick();
      tick();
      chk("wd_sticky", bus.fault, 1);
      chk("wd_idle", bus.busy, 0);

      bus.req0 = 1'b1;
      bus.len0 = 4'd5;
      grant("ab", 0, 4'd5);
      bus.req0 = 1'b0;
      tick();
      tick();
      tick();
      chk("ab_q12", bus.cnt_q, 12);
      reset = 1'b0;
      tick();
      chk("ab_busy", bus.busy, 0);
      chk("ab_done", {bus.done1, bus.done0}, 0);
      chk("ab_ack", {bus.ack1, bus.ack0}, 0);
      chk("ab_owner", bus.owner, 1);
      chk("ab_fault", bus.fault, 0);
      chk("ab_load", bus.cnt_load, 0);
      chk("ab_data", bus.cnt_data, 0);
      chk("ab_crst", bus.cnt_rst, 1);
      reset = 1'b1;
      seen  = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done0 || bus.busy)
            seen = 1;
      end
      chk("ab_quiet", seen, 0);

      bus.req0 = 1'b1;
      bus.len0 = 4'd2;
      grant("fr", 0, 4'd2);
      bus.req0 = 1'b0;
      wait_done("fr", 0, 4'd13, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
